// File: rtl/braun_mac_accum.sv
// braun_mac_accum
//   Multiply-accumulate controller for an external combinational 8x8 Braun
//   multiplier. Operand pairs arrive over a valid/ready handshake and are
//   registered onto mul_a/mul_b. One cycle later the product is added into an
//   ACC_W-bit accumulator. After the pair flagged in_last, the accumulator is
//   drained LSB-first, one byte per out_valid/out_ready handshake.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; in_a, in_b operands, in_last ends frame
//   mul_a, mul_b         registered operands to the multiplier
//   prod                 multiplier product (mul_a*mul_b)
//   out_valid/out_ready  result byte handshake; out_byte data, out_first on byte 0
//   frame_cnt            products summed this frame (saturating)
//   frame_ovf            sticky accumulator carry-out for this frame
module braun_mac_accum #(
  parameter int ACC_W   = 24,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_a,
  input  logic [7:0]         in_b,
  input  logic               in_last,
  output logic [7:0]         mul_a,
  output logic [7:0]         mul_b,
  input  logic [15:0]        prod,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               out_first,
  output logic [COUNT_W-1:0] frame_cnt,
  output logic               frame_ovf
);

  localparam int NBYTES = ACC_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_MUL    = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         mul_a_q, mul_a_d;
  logic [7:0]         mul_b_q, mul_b_d;
  logic               last_q, last_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // One extra bit captures the carry-out of the accumulator MSB.
  logic [ACC_W:0]     sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};
    state_d = state_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    last_d  = last_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;

    case (state_q)
      S_ACCEPT: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          last_d  = in_last;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        acc_d = sum[ACC_W-1:0];
        if (sum[ACC_W]) begin
          ovf_d = 1'b1;
        end
        if (cnt_q != {COUNT_W{1'b1}}) begin
          cnt_d = cnt_q + COUNT_W'(1);
        end
        idx_d   = '0;
        state_d = last_q ? S_DRAIN : S_ACCEPT;
      end

      S_DRAIN: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            // Final byte delivered: the frame is closed, start clean.
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
            state_d = S_ACCEPT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = S_ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACCEPT;
      mul_a_q <= '0;
      mul_b_q <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  // All outputs decode directly from registers.
  assign in_ready  = (state_q == S_ACCEPT);
  assign out_valid = (state_q == S_DRAIN);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_byte  = acc_q[8*idx_q +: 8];
  assign out_first = (idx_q == '0);
  assign frame_cnt = cnt_q;
  assign frame_ovf = ovf_q;

endmodule

// File: tb/tb_braun_mac_accum.sv
// Scoreboard bench for braun_mac_accum: stimulus pushes expected result bytes
// into a queue; a monitor pops and compares on every output handshake.
module tb_braun_mac_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic        in_last;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] prod;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_first;
  logic [7:0]  frame_cnt;
  logic        frame_ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] b;
    logic       first;
    logic [7:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  // 10 MHz clock
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stand-in for the Braun multiplier.
  assign prod = 16'(mul_a) * 16'(mul_b);

  braun_mac_accum #(.ACC_W(24), .COUNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .prod      (prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_first (out_first),
    .frame_cnt (frame_cnt),
    .frame_ovf (frame_ovf)
  );

  // Monitor: compare each delivered byte against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_byte got byte=%02h first=%0d cnt=%0d ovf=%0d, expected none",
                 out_byte, out_first, frame_cnt, frame_ovf);
      end else begin
        e = sb.pop_front();
        if (out_byte !== e.b || out_first !== e.first || frame_cnt !== e.cnt || frame_ovf !== e.ovf) begin
          failures = failures + 1;
          $display("FAIL out_byte got byte=%02h first=%0d cnt=%0d ovf=%0d, expected byte=%02h first=%0d cnt=%0d ovf=%0d",
                   out_byte, out_first, frame_cnt, frame_ovf, e.b, e.first, e.cnt, e.ovf);
        end else begin
          $display("byte %02h first=%0d cnt=%0d ovf=%0d ok", out_byte, out_first, frame_cnt, frame_ovf);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end else begin
      $display("%s = %0h ok", name, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input logic [23:0] sum, input logic [7:0] cnt, input logic ovf);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{b: sum[8*i +: 8], first: (i == 0), cnt: cnt, ovf: ovf});
    end
  endtask

  // Offer one pair and return just after the edge that accepts it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL in_ready_timeout got=0 expected=1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL drain_timeout got pending=%0d expected pending=0", sb.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_first"}, 32'(out_first), 32'd1);
    check({tag, "_out_byte"},  32'(out_byte),  32'd0);
    check({tag, "_mul_ab"},    {16'd0, mul_a, mul_b}, 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_frame_ovf"}, 32'(frame_ovf), 32'd0);
  endtask

  initial begin
    int t0, t1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // 1: 255*255 = 0xFE01, with latency check
    push_frame(24'h00FE01, 8'd1, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    check("t1_mul_cycle_out_valid", 32'(out_valid), 32'd0);
    check("t1_mul_cycle_in_ready",  32'(in_ready),  32'd0);
    tick();
    check("t1_drain_out_valid", 32'(out_valid), 32'd1);
    wait_drained();

    // 2: 20000 + 4335 + 8192 = 32527 = 0x7F0F
    push_frame(24'h007F0F, 8'd3, 1'b0);
    send(8'd100, 8'd200, 1'b0);
    send(8'd85,  8'd51,  1'b0);
    send(8'd128, 8'd64,  1'b1);
    wait_drained();

    // 3: 259 * 65025 = 16841475 -> wraps to 0xFB03, count saturates
    push_frame(24'h00FB03, 8'd255, 1'b1);
    for (int i = 0; i < 258; i++) send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    wait_drained();

    // 4: 15*15 = 0xE1 with downstream stalled for 5 cycles
    out_ready = 1'b0;
    push_frame(24'h0000E1, 8'd1, 1'b0);
    send(8'd15, 8'd15, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_out_valid", 32'(out_valid), 32'd1);
      check("t4_stall_out_byte",  32'(out_byte),  32'hE1);
      check("t4_stall_out_first", 32'(out_first), 32'd1);
      check("t4_stall_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_drained();

    // 5: reset mid-frame discards the partial sum
    send(8'd16, 8'd16, 1'b0);
    send(8'd16, 8'd16, 1'b0);
    tick();
    #10;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    #10;
    rst = 1'b0;
    tick();
    push_frame(24'h000001, 8'd1, 1'b0);
    send(8'd1, 8'd1, 1'b1);
    wait_drained();

    // 6: back-to-back frames; second accepted right after the final byte
    push_frame(24'h000000, 8'd1, 1'b0);
    push_frame(24'h0000FF, 8'd1, 1'b0);
    send(8'd0, 8'd0, 1'b1);
    t0 = cyc;
    send(8'd1, 8'd255, 1'b1);
    t1 = cyc;
    check("t6_accept_gap_cycles", 32'(t1 - t0), 32'd5);
    wait_drained();

    check("end_out_valid", 32'(out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
